dhash_multi: RTL and testbench
==============================

DHASH_MULTI -- requirements
Module: dhash_multi

Interface
REQ-001 SHALL have parameter customId, 8'h27, custom-instruction ID this block answers to.
REQ-002 SHALL have parameter IMG_W, 640, active pixels per line.
REQ-003 SHALL have parameter IMG_H, 480, active lines per frame.
REQ-004 SHALL have parameter GRID_W, 9, block columns; yields GRID_W-1 difference bits per block row.
REQ-005 SHALL have parameter GRID_H, 8, block rows.
REQ-006 SHALL have parameter PIX_W, 8, pixel width.
REQ-007 SHALL port clock  in  1  single system clock, all logic on rising edge.
REQ-008 SHALL port reset  in  1  asynchronous, active-low reset.
REQ-009 SHALL port camData  in  PIX_W  grayscale pixel, sampled when validCamera=1.
REQ-010 SHALL port validCamera  in  1  pixel strobe.
REQ-011 SHALL port hsync  in  1  one-cycle pulse at end of each line.
REQ-012 SHALL port vsync  in  1  one-cycle pulse at start of each frame.
REQ-013 SHALL port takeSignature  in  1  sampled at vsync; 1 = copy this frame's signature to reference at frame end.
REQ-014 SHALL port ciStart  in  1, ciN  in  8, ciValueA  in  32, ciValueB  in  32  custom-instruction request.
REQ-015 SHALL port ciDone  out  1, ciResult  out  32  custom-instruction response.
REQ-016 SHALL port motion  out  1, frameDone  out  1  (frameDone = one-cycle pulse at signature completion).

Function
REQ-017 SHALL reject elaboration unless SIG_BITS=(GRID_W-1)*GRID_H <= 64; blkW=IMG_W/GRID_W, blkH=IMG_H/GRID_H (integer division); pixels with column >= GRID_W*blkW and lines >= GRID_H*blkH ignored.
REQ-018 SHALL accumulate GRID_W block sums, each PIX_W+clog2(blkW*blkH) bits wide, unsigned, no saturation.
REQ-019 SHALL use FSM IDLE -> ACCUM (on vsync) -> ROWDIFF (on hsync closing last line of a block row) -> ACCUM or, after last block row, HAMMING -> DONE -> IDLE.
REQ-020 SHALL in ROWDIFF spend GRID_W-1 cycles, one per c: signature bit [r*(GRID_W-1)+c] = (sum[c] > sum[c+1]); then clear all sums.
REQ-021 SHALL drop pixels arriving in ROWDIFF, HAMMING or DONE and set sticky overrun flag.
REQ-022 SHALL in HAMMING spend SIG_BITS cycles counting bits where current differs from reference into 8-bit distance.
REQ-023 SHALL in DONE (one cycle): pulse frameDone, set motion = (distance > threshold), increment 8-bit frameCount (wraps 255->0), copy current to reference if takeSignature latched at vsync or capture armed, clear arm.
REQ-024 SHALL on vsync in any non-IDLE state abort: clear sums and counters, restart ACCUM; signature, reference, motion, frameCount unchanged.
REQ-025 SHALL accept a command when ciStart=1 and ciN=customId; ciDone=1 exactly the following cycle; ciDone=0 and ciResult=0 otherwise; back-to-back (held) requests each answered.
REQ-026 SHALL decode ciValueA[12:9]: 4'b1001 threshold <= ciValueB[7:0]; 4'b1011 arm capture; 4'b0000 read by ciValueA[3:0]: 0 cur[31:0], 1 cur[63:32], 2 ref[31:0], 3 ref[63:32], 4 status {frameCount[31:24], distance[23:16], 13'b0, overrun[2], busy[1], motion[0]}; read of status clears overrun; other codes/indices return 0.
REQ-027 SHALL zero-extend signature bits above SIG_BITS-1; busy = FSM not IDLE.
REQ-028 SHALL give CI writes priority-free independence from FSM; threshold change takes effect at next DONE.

Reset
REQ-029 SHALL on reset=0 force FSM IDLE, all sums, counters, signatures, distance, frameCount, overrun, arm, motion, frameDone, ciDone, ciResult to 0; threshold to 0.
REQ-030 SHALL resume only on first vsync after reset deasserts; reset mid-frame discards that frame.

Verification
REQ-031 Constant image 100, takeSignature=1 -> cur=ref=0, distance 0, motion 0, frameCount 1.
REQ-032 Threshold 1, then image with block c = 200-20c, takeSignature=0 -> cur words 0xFFFFFFFF/0xFFFFFFFF, distance 64, motion 1, frameDone one pulse.
REQ-033 Arm capture (ciValueA=0x1600) then REQ-032 frame -> ref equals 0xFFFFFFFF_FFFFFFFF after DONE; next identical frame -> distance 0, motion 0.
REQ-034 vsync pulse mid-frame at line 200 -> no frameDone for aborted frame; next full frame completes normally.
REQ-035 Pixel during ROWDIFF -> status bit2=1; second status read -> bit2=0.
REQ-036 ciStart=1, ciN=0x27 held 5 cycles with read index 4 -> ciDone high cycles 2-6, status value each cycle; ciN=0 -> ciDone 0, ciResult 0.

Source files
------------

// File: rtl/dhash_multi.sv
// Difference-hash motion detector: per-block pixel sums, horizontal gradient signature,
// Hamming distance against a reference signature, and a custom-instruction register port.
module dhash_multi #(
    parameter logic [7:0] customId = 8'h27,
    parameter int         IMG_W    = 640,
    parameter int         IMG_H    = 480,
    parameter int         GRID_W   = 9,
    parameter int         GRID_H   = 8,
    parameter int         PIX_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PIX_W-1:0] camData,
    input  logic             validCamera,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             takeSignature,
    input  logic             ciStart,
    input  logic [7:0]       ciN,
    input  logic [31:0]      ciValueA,
    input  logic [31:0]      ciValueB,
    output logic             ciDone,
    output logic [31:0]      ciResult,
    output logic             motion,
    output logic             frameDone
);

    localparam int SIG_BITS = (GRID_W - 1) * GRID_H;
    localparam int BLK_W    = IMG_W / GRID_W;
    localparam int BLK_H    = IMG_H / GRID_H;
    localparam int SUM_W    = PIX_W + $clog2(BLK_W * BLK_H);
    localparam int COL_W    = $clog2(GRID_W + 1);
    localparam int ROW_W    = $clog2(GRID_H + 1);
    localparam int PXC_W    = $clog2(BLK_W + 1);
    localparam int LNC_W    = $clog2(BLK_H + 1);
    localparam logic [5:0] HAM_LAST = 6'(SIG_BITS - 1);

    if (SIG_BITS > 64 || GRID_W < 2 || BLK_W < 1 || BLK_H < 1) begin : g_cfg_check
        $error("dhash_multi: unsupported grid/image configuration");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_ROWDIFF,
        S_HAMMING,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   sum_q [GRID_W];
    logic [SUM_W-1:0]   sum_d [GRID_W];
    logic [PXC_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [COL_W-1:0]   blk_col_q, blk_col_d;
    logic [LNC_W-1:0]   line_cnt_q, line_cnt_d;
    logic [ROW_W-1:0]   blk_row_q, blk_row_d;
    logic [COL_W-1:0]   rd_idx_q, rd_idx_d;
    logic [5:0]         ham_idx_q, ham_idx_d;
    logic [63:0]        work_sig_q, work_sig_d;
    logic [63:0]        cur_sig_q, cur_sig_d;
    logic [63:0]        ref_sig_q, ref_sig_d;
    logic [7:0]         distance_q, distance_d;
    logic [7:0]         frame_count_q, frame_count_d;
    logic [7:0]         threshold_q, threshold_d;
    logic               overrun_q, overrun_d;
    logic               arm_q, arm_d;
    logic               take_q, take_d;
    logic               motion_q, motion_d;
    logic               frame_done_q, frame_done_d;
    logic               ci_done_q, ci_done_d;
    logic [31:0]        ci_result_q, ci_result_d;

    logic [5:0]         sig_idx;
    logic [31:0]        read_data;
    logic               busy;
    logic               unused_ci_bits;

    assign busy           = (state_q != S_IDLE);
    assign unused_ci_bits = ^{ciValueA[31:13], ciValueA[8:4], ciValueB[31:8]};

    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        pix_cnt_d     = pix_cnt_q;
        blk_col_d     = blk_col_q;
        line_cnt_d    = line_cnt_q;
        blk_row_d     = blk_row_q;
        rd_idx_d      = rd_idx_q;
        ham_idx_d     = ham_idx_q;
        work_sig_d    = work_sig_q;
        cur_sig_d     = cur_sig_q;
        ref_sig_d     = ref_sig_q;
        distance_d    = distance_q;
        frame_count_d = frame_count_q;
        threshold_d   = threshold_q;
        overrun_d     = overrun_q;
        arm_d         = arm_q;
        take_d        = take_q;
        motion_d      = motion_q;
        frame_done_d  = 1'b0;
        ci_done_d     = 1'b0;
        ci_result_d   = '0;
        sig_idx       = 6'(blk_row_q * (GRID_W - 1)) + 6'(rd_idx_q);

        // A vsync always (re)starts accumulation; mid-frame it aborts without touching results.
        if (vsync) begin
            state_d    = S_ACCUM;
            sum_d      = '{default: '0};
            pix_cnt_d  = '0;
            blk_col_d  = '0;
            line_cnt_d = '0;
            blk_row_d  = '0;
            rd_idx_d   = '0;
            ham_idx_d  = '0;
            take_d     = takeSignature;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (validCamera) begin
                        if (blk_col_q < COL_W'(GRID_W)) begin
                            sum_d[blk_col_q] = sum_q[blk_col_q] + SUM_W'(camData);
                        end
                        if (pix_cnt_q == PXC_W'(BLK_W - 1)) begin
                            pix_cnt_d = '0;
                            if (blk_col_q != COL_W'(GRID_W)) begin
                                blk_col_d = blk_col_q + 1'b1;
                            end
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end
                    if (hsync) begin
                        pix_cnt_d = '0;
                        blk_col_d = '0;
                        if (line_cnt_q == LNC_W'(BLK_H - 1)) begin
                            line_cnt_d = '0;
                            rd_idx_d   = '0;
                            state_d    = S_ROWDIFF;
                        end else begin
                            line_cnt_d = line_cnt_q + 1'b1;
                        end
                    end
                end
                S_ROWDIFF: begin
                    work_sig_d[sig_idx] = (sum_q[rd_idx_q] > sum_q[rd_idx_q + 1'b1]);
                    if (rd_idx_q == COL_W'(GRID_W - 2)) begin
                        sum_d = '{default: '0};
                        if (blk_row_q == ROW_W'(GRID_H - 1)) begin
                            ham_idx_d  = '0;
                            distance_d = '0;
                            state_d    = S_HAMMING;
                        end else begin
                            blk_row_d = blk_row_q + 1'b1;
                            state_d   = S_ACCUM;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
                S_HAMMING: begin
                    if (work_sig_q[ham_idx_q] != ref_sig_q[ham_idx_q]) begin
                        distance_d = distance_q + 8'd1;
                    end
                    if (ham_idx_q == HAM_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        ham_idx_d = ham_idx_q + 6'd1;
                    end
                end
                S_DONE: begin
                    frame_done_d  = 1'b1;
                    motion_d      = (distance_q > threshold_q);
                    frame_count_d = frame_count_q + 8'd1;
                    cur_sig_d     = work_sig_q;
                    if (take_q || arm_q) begin
                        ref_sig_d = work_sig_q;
                    end
                    arm_d   = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        case (ciValueA[3:0])
            4'd0:    read_data = cur_sig_q[31:0];
            4'd1:    read_data = cur_sig_q[63:32];
            4'd2:    read_data = ref_sig_q[31:0];
            4'd3:    read_data = ref_sig_q[63:32];
            4'd4:    read_data = {frame_count_q, distance_q, 13'b0, overrun_q, busy, motion_q};
            default: read_data = '0;
        endcase

        // CI writes come after the FSM so a same-cycle arm request survives DONE clearing it.
        if (ciStart && (ciN == customId)) begin
            ci_done_d = 1'b1;
            case (ciValueA[12:9])
                4'b1001: threshold_d = ciValueB[7:0];
                4'b1011: arm_d = 1'b1;
                4'b0000: begin
                    ci_result_d = read_data;
                    if (ciValueA[3:0] == 4'd4) begin
                        overrun_d = 1'b0;
                    end
                end
                default: ci_result_d = '0;
            endcase
        end

        if (validCamera && (state_q == S_ROWDIFF || state_q == S_HAMMING || state_q == S_DONE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            sum_q         <= '{default: '0};
            pix_cnt_q     <= '0;
            blk_col_q     <= '0;
            line_cnt_q    <= '0;
            blk_row_q     <= '0;
            rd_idx_q      <= '0;
            ham_idx_q     <= '0;
            work_sig_q    <= '0;
            cur_sig_q     <= '0;
            ref_sig_q     <= '0;
            distance_q    <= '0;
            frame_count_q <= '0;
            threshold_q   <= '0;
            overrun_q     <= 1'b0;
            arm_q         <= 1'b0;
            take_q        <= 1'b0;
            motion_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            ci_done_q     <= 1'b0;
            ci_result_q   <= '0;
        end else begin
            state_q       <= state_d;
            sum_q         <= sum_d;
            pix_cnt_q     <= pix_cnt_d;
            blk_col_q     <= blk_col_d;
            line_cnt_q    <= line_cnt_d;
            blk_row_q     <= blk_row_d;
            rd_idx_q      <= rd_idx_d;
            ham_idx_q     <= ham_idx_d;
            work_sig_q    <= work_sig_d;
            cur_sig_q     <= cur_sig_d;
            ref_sig_q     <= ref_sig_d;
            distance_q    <= distance_d;
            frame_count_q <= frame_count_d;
            threshold_q   <= threshold_d;
            overrun_q     <= overrun_d;
            arm_q         <= arm_d;
            take_q        <= take_d;
            motion_q      <= motion_d;
            frame_done_q  <= frame_done_d;
            ci_done_q     <= ci_done_d;
            ci_result_q   <= ci_result_d;
        end
    end

    assign ciDone    = ci_done_q;
    assign ciResult  = ci_result_q;
    assign motion    = motion_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_dhash_multi.sv
// Self-checking bench for dhash_multi on a reduced 20x16 image (2x2 blocks, 64-bit signature);
// columns 18-19 carry 0xFF and must never reach any block sum.
module tb_dhash_multi;

    localparam int IMG_W     = 20;
    localparam int IMG_H     = 16;
    localparam int GRID_W    = 9;
    localparam int GRID_H    = 8;
    localparam int PIX_W     = 8;
    localparam int BLK_W     = IMG_W / GRID_W;
    localparam int BLK_H     = IMG_H / GRID_H;
    localparam int USED_COLS = GRID_W * BLK_W;

    logic             clock         = 1'b0;
    logic             reset         = 1'b0;
    logic [PIX_W-1:0] camData       = '0;
    logic             validCamera   = 1'b0;
    logic             hsync         = 1'b0;
    logic             vsync         = 1'b0;
    logic             takeSignature = 1'b0;
    logic             ciStart       = 1'b0;
    logic [7:0]       ciN           = '0;
    logic [31:0]      ciValueA      = '0;
    logic [31:0]      ciValueB      = '0;
    logic             ciDone;
    logic [31:0]      ciResult;
    logic             motion;
    logic             frameDone;

    int checks     = 0;
    int passes     = 0;
    int donePulses = 0;

    typedef struct {
        string       name;
        int          mode;
        logic        take;
        logic        arm;
        logic        setThr;
        logic [7:0]  thr;
        logic [31:0] curLo;
        logic [31:0] curHi;
        logic [31:0] refLo;
        logic [31:0] refHi;
        logic [31:0] status;
    } vec_t;

    vec_t vecs[7];

    dhash_multi #(
        .customId(8'h27),
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .PIX_W   (PIX_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .camData      (camData),
        .validCamera  (validCamera),
        .hsync        (hsync),
        .vsync        (vsync),
        .takeSignature(takeSignature),
        .ciStart      (ciStart),
        .ciN          (ciN),
        .ciValueA     (ciValueA),
        .ciValueB     (ciValueB),
        .ciDone       (ciDone),
        .ciResult     (ciResult),
        .motion       (motion),
        .frameDone    (frameDone)
    );

    always #5 clock = ~clock;

    // Count frameDone pulses so every frame can be checked for exactly one.
    always @(negedge clock) begin
        if (frameDone === 1'b1) donePulses++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    endtask

    // Mode 0: flat grey 100. Mode 1: block column c holds 200-20c (strictly decreasing sums).
    function automatic logic [7:0] pixelValue(input int mode, input int col);
        if (col >= USED_COLS) return 8'hFF;
        if (mode == 0) return 8'd100;
        return 8'(200 - 20 * (col / BLK_W));
    endfunction

    task automatic ciCmd(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                         output logic d, output logic [31:0] r);
        @(negedge clock);
        ciStart  = 1'b1;
        ciN      = n;
        ciValueA = a;
        ciValueB = b;
        @(negedge clock);
        d        = ciDone;
        r        = ciResult;
        ciStart  = 1'b0;
        ciN      = '0;
        ciValueA = '0;
        ciValueB = '0;
    endtask

    task automatic ciRead(input logic [31:0] a, output logic [31:0] r);
        logic d;
        ciCmd(8'h27, a, 32'd0, d, r);
        checkOutput("ciDone_read", 64'(d), 64'd1);
    endtask

    task automatic ciWrite(input logic [31:0] a, input logic [31:0] b);
        logic d;
        logic [31:0] r;
        ciCmd(8'h27, a, b, d, r);
        checkOutput("ciDone_write", 64'(d), 64'd1);
    endtask

    // vsync, then 'lines' lines of pixels, each closed by hsync and a gap longer than ROWDIFF.
    task automatic applyStimulus(input int mode, input logic take, input int lines, input logic overrunPixel);
        @(negedge clock);
        vsync         = 1'b1;
        takeSignature = take;
        @(negedge clock);
        vsync         = 1'b0;
        takeSignature = 1'b0;
        repeat (2) @(negedge clock);
        for (int line = 0; line < lines; line++) begin
            for (int col = 0; col < IMG_W; col++) begin
                validCamera = 1'b1;
                camData     = pixelValue(mode, col);
                @(negedge clock);
            end
            validCamera = 1'b0;
            hsync       = 1'b1;
            @(negedge clock);
            hsync = 1'b0;
            if (overrunPixel && line == BLK_H - 1) begin
                validCamera = 1'b1;
                camData     = 8'h55;
                @(negedge clock);
                validCamera = 1'b0;
            end
            repeat (10) @(negedge clock);
        end
    endtask

    task automatic waitFrameDone(input int startCount);
        for (int i = 0; i < 300 && donePulses == startCount; i++) @(negedge clock);
        repeat (5) @(negedge clock);
        checkOutput("frameDone_pulses", 64'(donePulses - startCount), 64'd1);
    endtask

    task automatic checkFrame(input vec_t v);
        logic [31:0] r;
        ciRead(32'd0, r); checkOutput({v.name, "_curLo"}, 64'(r), 64'(v.curLo));
        ciRead(32'd1, r); checkOutput({v.name, "_curHi"}, 64'(r), 64'(v.curHi));
        ciRead(32'd2, r); checkOutput({v.name, "_refLo"}, 64'(r), 64'(v.refLo));
        ciRead(32'd3, r); checkOutput({v.name, "_refHi"}, 64'(r), 64'(v.refHi));
        ciRead(32'd4, r); checkOutput({v.name, "_status"}, 64'(r), 64'(v.status));
        checkOutput({v.name, "_motion"}, 64'(motion), 64'(v.status[0]));
    endtask

    initial begin
        logic [31:0] r;
        logic        d;
        int          startCount;

        vecs[0] = '{"const_take",   0, 1'b1, 1'b0, 1'b0, 8'd0,  32'h0, 32'h0, 32'h0, 32'h0, 32'h01000000};
        vecs[1] = '{"grad_thr1",    1, 1'b0, 1'b0, 1'b1, 8'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h02400001};
        vecs[2] = '{"grad_arm",     1, 1'b0, 1'b1, 1'b0, 8'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h03400001};
        vecs[3] = '{"grad_same",    1, 1'b0, 1'b0, 1'b0, 8'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h04000000};
        vecs[4] = '{"const_vs_ref", 0, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h05400001};
        vecs[5] = '{"thr_eq_dist",  0, 1'b0, 1'b0, 1'b1, 8'd64, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h06400000};
        vecs[6] = '{"thr_below",    0, 1'b1, 1'b0, 1'b1, 8'd63, 32'h0, 32'h0, 32'h0, 32'h0, 32'h07400001};

        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("reset_ciDone", 64'(ciDone), 64'd0);
        checkOutput("reset_ciResult", 64'(ciResult), 64'd0);
        checkOutput("reset_frameDone", 64'(frameDone), 64'd0);
        checkOutput("reset_motion", 64'(motion), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        ciRead(32'd4, r); checkOutput("status_after_reset", 64'(r), 64'd0);
        ciRead(32'd0, r); checkOutput("cur_after_reset", 64'(r), 64'd0);

        // Table-driven full frames
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].setThr) ciWrite(32'h0000_1200, 32'(vecs[i].thr));
            if (vecs[i].arm) ciWrite(32'h0000_1600, 32'd0);
            startCount = donePulses;
            applyStimulus(vecs[i].mode, vecs[i].take, IMG_H, 1'b0);
            waitFrameDone(startCount);
            checkFrame(vecs[i]);
        end

        // Abort: vsync mid-frame discards it, the following frame completes normally
        startCount = donePulses;
        applyStimulus(1, 1'b0, 5, 1'b0);
        ciRead(32'd4, r); checkOutput("busy_midframe", 64'(r[1]), 64'd1);
        ciRead(32'd0, r); checkOutput("cur_kept_midframe", 64'(r), 64'd0);
        checkOutput("no_done_abort", 64'(donePulses - startCount), 64'd0);
        applyStimulus(1, 1'b0, IMG_H, 1'b0);
        waitFrameDone(startCount);
        ciRead(32'd0, r); checkOutput("abort_next_curLo", 64'(r), 64'hFFFFFFFF);
        ciRead(32'd4, r); checkOutput("abort_next_status", 64'(r), 64'h08400001);

        // Held request: one answer per cycle, each carrying the status word
        @(negedge clock);
        for (int i = 0; i <= 6; i++) begin
            checkOutput("held_ciDone", 64'(ciDone), (i >= 1 && i <= 5) ? 64'd1 : 64'd0);
            checkOutput("held_ciResult", 64'(ciResult), (i >= 1 && i <= 5) ? 64'h08400001 : 64'd0);
            ciStart  = (i < 5);
            ciN      = 8'h27;
            ciValueA = 32'd4;
            @(negedge clock);
        end
        ciStart  = 1'b0;
        ciValueA = '0;
        ciCmd(8'h00, 32'd4, 32'd0, d, r);
        checkOutput("wrongN_ciDone", 64'(d), 64'd0);
        checkOutput("wrongN_ciResult", 64'(r), 64'd0);
        ciCmd(8'h27, 32'd5, 32'd0, d, r);
        checkOutput("badIndex_ciDone", 64'(d), 64'd1);
        checkOutput("badIndex_ciResult", 64'(r), 64'd0);
        ciCmd(8'h27, 32'h0000_0200, 32'd0, d, r);
        checkOutput("badCode_ciResult", 64'(r), 64'd0);

        // Reset in the middle of a frame
        applyStimulus(1, 1'b0, 3, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("midreset_motion", 64'(motion), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        ciRead(32'd4, r); checkOutput("midreset_status", 64'(r), 64'd0);
        ciRead(32'd0, r); checkOutput("midreset_curLo", 64'(r), 64'd0);
        ciRead(32'd1, r); checkOutput("midreset_curHi", 64'(r), 64'd0);

        // Overrun: a pixel right after the block-row hsync is dropped and flagged once
        startCount = donePulses;
        applyStimulus(0, 1'b0, IMG_H, 1'b1);
        waitFrameDone(startCount);
        ciRead(32'd0, r); checkOutput("overrun_curLo", 64'(r), 64'd0);
        ciRead(32'd4, r); checkOutput("overrun_status_first", 64'(r), 64'h01000004);
        ciRead(32'd4, r); checkOutput("overrun_status_second", 64'(r), 64'h01000000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
